// File: rtl/proc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// proc_ctrl_pkg
//   Shared types and helpers for the multicycle register-bus processor
//   controller: FSM state encoding, opcode encoding and instruction-field
//   slicing helpers. Instruction layout (DW = 3 + 2*RW):
//     [DW-1:DW-3] opcode, [2*RW-1:RW] X register, [RW-1:0] Y register.
// -----------------------------------------------------------------------------
package proc_ctrl_pkg;

    localparam int unsigned OPW = 3;

    typedef enum logic [4:0] {
        S_RESET = 5'd0,
        S_FA    = 5'd1,
        S_FW    = 5'd2,
        S_FL    = 5'd3,
        S_DEC   = 5'd4,
        S_MVI_A = 5'd5,
        S_MVI_W = 5'd6,
        S_MVI_L = 5'd7,
        S_A1    = 5'd8,
        S_A2    = 5'd9,
        S_A3    = 5'd10,
        S_LD_A  = 5'd11,
        S_LD_W  = 5'd12,
        S_LD_L  = 5'd13,
        S_ST_D  = 5'd14,
        S_ST_A  = 5'd15,
        S_ST_W  = 5'd16,
        S_HALT  = 5'd17
    } state_t;

    typedef enum logic [OPW-1:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_LD   = 3'd4,
        OP_ST   = 3'd5,
        OP_MVNZ = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    // Helpers take the instruction zero-extended to 32 bits so one function
    // serves every RW; the opcode always sits directly above the two fields.
    function automatic opcode_t ir_opcode(input logic [31:0] ir_w, input int unsigned rw);
        logic [31:0] s;
        s = ir_w >> (2 * rw);
        return opcode_t'(s[OPW-1:0]);
    endfunction

    function automatic logic [31:0] ir_field(input logic [31:0] ir_w,
                                             input int unsigned lsb,
                                             input int unsigned rw);
        return (ir_w >> lsb) & ((32'd1 << rw) - 32'd1);
    endfunction

endpackage

// File: rtl/proc_ctrl_fsm_p_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
//   Register index to one-hot select decoder.
//   idx_i    : RW-bit register index
//   onehot_o : NREG-bit one-hot select (bit idx_i set)
// -----------------------------------------------------------------------------
module onehot_dec #(
    parameter  int unsigned RW   = 3,
    localparam int unsigned NREG = 1 << RW
) (
    input  logic [RW-1:0]   idx_i,
    output logic [NREG-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/proc_ctrl_fsm_p.sv
// -----------------------------------------------------------------------------
// proc_ctrl_fsm_p
//   Control unit for the multicycle register-bus processor. Fetches an
//   instruction into IR, decodes opcode/X/Y and sequences register enables
//   and bus/ALU/memory strobes. Memory accesses wait on mem_ready; run=0
//   freezes the FSM and forces every strobe low.
//
//   clk, rst (async, active-low), run        : clock, reset, advance enable
//   din                                      : memory read data / instruction
//   g                                        : ALU result register (MVNZ test)
//   mem_ready                                : memory access complete
//   r_in, r_out                              : one-hot register load / drive
//   din_out, g_out                           : bus drive from din / G
//   ir_in, a_in, g_in, add_sub               : IR, A, G loads; 1 = subtract
//   addr_in, dout_in, w_d, incr_pc           : addr/data-out load, write, PC++
//   done, halted                             : instruction complete, HALT seen
//   ir, state                                : instruction register, FSM state
// -----------------------------------------------------------------------------
module proc_ctrl_fsm_p
    import proc_ctrl_pkg::*;
#(
    parameter  int unsigned RW   = 3,
    localparam int unsigned DW   = 3 + 2 * RW,
    localparam int unsigned NREG = 1 << RW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [DW-1:0]   din,
    input  logic [DW-1:0]   g,
    input  logic            mem_ready,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] r_out,
    output logic            din_out,
    output logic            g_out,
    output logic            ir_in,
    output logic            a_in,
    output logic            g_in,
    output logic            add_sub,
    output logic            addr_in,
    output logic            dout_in,
    output logic            w_d,
    output logic            incr_pc,
    output logic            done,
    output logic            halted,
    output logic [DW-1:0]   ir,
    output logic [4:0]      state
);

    localparam logic [NREG-1:0] PC_OH = {1'b1, {(NREG - 1){1'b0}}};

    state_t          state_q, state_d;
    logic [DW-1:0]   ir_q;
    logic            fw_incr_q, fw_incr_d;
    logic [31:0]     ir_w;
    opcode_t         opcode;
    logic [RW-1:0]   x_idx, y_idx;
    logic [NREG-1:0] x_oh, y_oh;

    assign ir_w   = 32'(ir_q);
    assign opcode = ir_opcode(ir_w, RW);
    assign x_idx  = RW'(ir_field(ir_w, RW, RW));
    assign y_idx  = RW'(ir_field(ir_w, 0, RW));

    onehot_dec #(.RW(RW)) u_dec_x (.idx_i(x_idx), .onehot_o(x_oh));
    onehot_dec #(.RW(RW)) u_dec_y (.idx_i(y_idx), .onehot_o(y_oh));

    assign ir     = ir_q;
    assign state  = state_q;
    assign halted = (state_q == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RESET;
            ir_q      <= '0;
            fw_incr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fw_incr_q <= fw_incr_d;
            if (ir_in) ir_q <= din;
        end
    end

    // All strobes come from state/IR and are only raised while run=1, so a
    // frozen controller leaves the datapath completely idle.
    always_comb begin
        state_d   = state_q;
        fw_incr_d = fw_incr_q;
        r_in      = '0;
        r_out     = '0;
        din_out   = 1'b0;
        g_out     = 1'b0;
        ir_in     = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        add_sub   = 1'b0;
        addr_in   = 1'b0;
        dout_in   = 1'b0;
        w_d       = 1'b0;
        incr_pc   = 1'b0;
        done      = 1'b0;
        if (run) begin
            case (state_q)
                S_RESET: state_d = S_FA;
                S_FA: begin
                    r_out     = PC_OH;
                    addr_in   = 1'b1;
                    fw_incr_d = 1'b0;
                    state_d   = S_FW;
                end
                // PC advances once per fetch no matter how long memory stalls.
                S_FW: begin
                    incr_pc   = ~fw_incr_q;
                    fw_incr_d = 1'b1;
                    if (mem_ready) state_d = S_FL;
                end
                S_FL: begin
                    ir_in   = 1'b1;
                    state_d = S_DEC;
                end
                S_DEC: begin
                    case (opcode)
                        OP_MV: begin
                            r_in    = x_oh;
                            r_out   = y_oh;
                            done    = 1'b1;
                            state_d = S_FA;
                        end
                        OP_MVI:  state_d = S_MVI_A;
                        OP_ADD,
                        OP_SUB:  state_d = S_A1;
                        OP_LD:   state_d = S_LD_A;
                        OP_ST:   state_d = S_ST_D;
                        OP_MVNZ: begin
                            if (|g) begin
                                r_in  = x_oh;
                                r_out = y_oh;
                            end
                            done    = 1'b1;
                            state_d = S_FA;
                        end
                        OP_HALT: state_d = S_HALT;
                        default: state_d = S_FA;
                    endcase
                end
                S_MVI_A: begin
                    r_out   = PC_OH;
                    addr_in = 1'b1;
                    state_d = S_MVI_W;
                end
                S_MVI_W: if (mem_ready) state_d = S_MVI_L;
                S_MVI_L: begin
                    din_out = 1'b1;
                    r_in    = x_oh;
                    incr_pc = 1'b1;
                    done    = 1'b1;
                    state_d = S_FA;
                end
                S_A1: begin
                    r_out   = x_oh;
                    a_in    = 1'b1;
                    state_d = S_A2;
                end
                S_A2: begin
                    r_out   = y_oh;
                    g_in    = 1'b1;
                    add_sub = (opcode == OP_SUB);
                    state_d = S_A3;
                end
                S_A3: begin
                    g_out   = 1'b1;
                    r_in    = x_oh;
                    done    = 1'b1;
                    state_d = S_FA;
                end
                S_LD_A: begin
                    r_out   = y_oh;
                    addr_in = 1'b1;
                    state_d = S_LD_W;
                end
                S_LD_W: if (mem_ready) state_d = S_LD_L;
                S_LD_L: begin
                    din_out = 1'b1;
                    r_in    = x_oh;
                    done    = 1'b1;
                    state_d = S_FA;
                end
                S_ST_D: begin
                    r_out   = x_oh;
                    dout_in = 1'b1;
                    state_d = S_ST_A;
                end
                S_ST_A: begin
                    r_out   = y_oh;
                    addr_in = 1'b1;
                    state_d = S_ST_W;
                end
                S_ST_W: begin
                    w_d = 1'b1;
                    if (mem_ready) begin
                        done    = 1'b1;
                        state_d = S_FA;
                    end
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_ctrl_fsm_p.sv
module tb_proc_ctrl_fsm_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, load;
    int unsigned mem_delay;
    int          errors = 0;
    int          checks = 0;
    logic [8:0]  pq[$];

    // Two builds: k=0 -> RW=3 (DW=9), k=1 -> RW=4 (DW=11). Each carries a
    // datapath/RAM model driven purely by the controller's strobes.
    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int unsigned RWK = 3 + k;
        localparam int unsigned DWK = 3 + 2 * RWK;
        localparam int unsigned NR  = 1 << RWK;
        localparam int unsigned MW  = 1 << DWK;

        logic [DWK-1:0] din, g, ir, bus;
        logic           mem_ready;
        logic [NR-1:0]  r_in, r_out;
        logic din_out, g_out, ir_in, a_in, g_in, add_sub;
        logic addr_in, dout_in, w_d, incr_pc, done, halted;
        logic [4:0]     state;
        logic [DWK-1:0] R [NR];
        logic [DWK-1:0] A, G, ADDR, DOUT;
        logic [DWK-1:0] ram  [MW];
        logic [DWK-1:0] prog [MW];
        int unsigned    wcnt, n_done, n_incr, n_fw, n_wd, n_as;
        int unsigned    bus_viol = 0, irin_viol = 0;
        logic [4:0]     last_done_st;
        logic [2*NR+10:0] strobes;

        assign strobes   = {r_in, r_out, din_out, g_out, ir_in, a_in, g_in, add_sub,
                            addr_in, dout_in, w_d, incr_pc, done};
        assign g         = G;
        assign din       = ram[ADDR];
        assign mem_ready = (wcnt >= mem_delay);

        always_comb begin
            bus = '0;
            for (int i = 0; i < NR; i++) if (r_out[i]) bus = bus | R[i];
            if (din_out) bus = bus | din;
            if (g_out)   bus = bus | G;
        end

        proc_ctrl_fsm_p #(.RW(RWK)) dut (
            .clk(clk), .rst(rst), .run(run), .din(din), .g(g), .mem_ready(mem_ready),
            .r_in(r_in), .r_out(r_out), .din_out(din_out), .g_out(g_out),
            .ir_in(ir_in), .a_in(a_in), .g_in(g_in), .add_sub(add_sub),
            .addr_in(addr_in), .dout_in(dout_in), .w_d(w_d), .incr_pc(incr_pc),
            .done(done), .halted(halted), .ir(ir), .state(state)
        );

        always @(posedge clk) begin
            if (load) begin
                ram  <= prog;
                for (int i = 0; i < NR; i++) R[i] <= '0;
                A <= '0; G <= '0; ADDR <= '0; DOUT <= '0;
                wcnt <= 0; n_done <= 0; n_incr <= 0; n_fw <= 0; n_wd <= 0; n_as <= 0;
                last_done_st <= '0;
            end else if (rst) begin
                if (incr_pc) R[NR-1] <= R[NR-1] + 1'b1;
                for (int i = 0; i < NR; i++) if (r_in[i]) R[i] <= bus;
                if (a_in)    A    <= bus;
                if (g_in)    G    <= add_sub ? A - bus : A + bus;
                if (addr_in) ADDR <= bus;
                if (dout_in) DOUT <= bus;
                if (w_d && mem_ready) ram[ADDR] <= DOUT;
                wcnt <= addr_in ? 0 : ((wcnt < 100) ? wcnt + 1 : wcnt);
                if (incr_pc) n_incr <= n_incr + 1;
                if (state == 5'd2) n_fw <= n_fw + 1;
                if (w_d) n_wd <= n_wd + 1;
                if (add_sub) n_as <= n_as + 1;
                if (done) begin
                    n_done       <= n_done + 1;
                    last_done_st <= state;
                end
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                a_bus: assert (($countones(r_out) + int'(din_out) + int'(g_out)) <= 1)
                    else $error("FAIL bus_contention cfg%0d r_out=%h din_out=%b g_out=%b",
                                k, r_out, din_out, g_out);
                if (($countones(r_out) + int'(din_out) + int'(g_out)) > 1)
                    bus_viol <= bus_viol + 1;
                if (ir_in && state != 5'd3) irin_viol <= irin_viol + 1;
            end
        end
    end

    task automatic load0();
        for (int i = 0; i < 512; i++) g_cfg[0].prog[i] = '0;
        foreach (pq[i]) g_cfg[0].prog[i] = pq[i];
    endtask

    task automatic start(input int unsigned dly);
        mem_delay = dly;
        rst  = 1'b0;
        run  = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        rst  = 1'b1;
        run  = 1'b1;
    endtask

    task automatic wait_done0(input int unsigned n);
        for (int i = 0; i < 3000 && g_cfg[0].n_done < n; i++) @(negedge clk);
        checks++;
        if (g_cfg[0].n_done < n) begin
            errors++;
            $display("FAIL done_timeout: got %0d done pulses, required %0d", g_cfg[0].n_done, n);
        end
    endtask

    task automatic test_reset();
        pq = {9'h000};
        load0();
        mem_delay = 0;
        rst = 1'b0; run = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        checks++; if (g_cfg[0].state !== 5'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", g_cfg[0].state); end
        checks++; if (g_cfg[0].ir !== 9'h000) begin errors++; $display("FAIL reset_ir: got %h, required 000", g_cfg[0].ir); end
        checks++; if (g_cfg[0].strobes !== '0) begin errors++; $display("FAIL reset_strobes: got %h, required 0", g_cfg[0].strobes); end
        checks++; if (g_cfg[0].halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b, required 0", g_cfg[0].halted); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (g_cfg[0].state !== 5'd1) begin errors++; $display("FAIL first_fa: got %0d, required 1", g_cfg[0].state); end
        checks++; if (g_cfg[0].r_out !== 8'h80 || g_cfg[0].addr_in !== 1'b1) begin errors++;
            $display("FAIL fa_strobes: got r_out=%h addr_in=%b, required 80/1", g_cfg[0].r_out, g_cfg[0].addr_in); end
    endtask

    task automatic test_mvi();
        pq = {9'h050, 9'h005, 9'h1C0};
        load0();
        for (int pass = 0; pass < 2; pass++) begin
            start(pass == 0 ? 0 : 3);
            wait_done0(1);
            checks++; if (g_cfg[0].R[2] !== 9'h005) begin errors++; $display("FAIL mvi_r2: got %h, required 005", g_cfg[0].R[2]); end
            checks++; if (g_cfg[0].R[7] !== 9'h002) begin errors++; $display("FAIL mvi_pc: got %h, required 002", g_cfg[0].R[7]); end
            checks++; if (g_cfg[0].n_incr !== 2) begin errors++; $display("FAIL mvi_incr_pc: got %0d pulses, required 2", g_cfg[0].n_incr); end
            checks++; if (g_cfg[0].n_fw !== (pass == 0 ? 1 : 4)) begin errors++;
                $display("FAIL mvi_fetch_wait: got %0d cycles, required %0d", g_cfg[0].n_fw, pass == 0 ? 1 : 4); end
            checks++; if (g_cfg[0].last_done_st !== 5'd7) begin errors++; $display("FAIL mvi_done_state: got %0d, required 7", g_cfg[0].last_done_st); end
        end
    endtask

    task automatic test_alu();
        pq = {9'h040, 9'h007, 9'h048, 9'h003, 9'h081, 9'h040, 9'h007, 9'h0C1, 9'h1C0};
        load0();
        start(1);
        wait_done0(3);
        checks++; if (g_cfg[0].R[0] !== 9'h00A) begin errors++; $display("FAIL add_r0: got %h, required 00a", g_cfg[0].R[0]); end
        checks++; if (g_cfg[0].n_as !== 0) begin errors++; $display("FAIL add_sub_in_add: got %0d, required 0", g_cfg[0].n_as); end
        wait_done0(5);
        checks++; if (g_cfg[0].R[0] !== 9'h004) begin errors++; $display("FAIL sub_r0: got %h, required 004", g_cfg[0].R[0]); end
        checks++; if (g_cfg[0].n_as !== 1) begin errors++; $display("FAIL add_sub_in_sub: got %0d, required 1", g_cfg[0].n_as); end
    endtask

    task automatic test_st_ld();
        pq = {9'h058, 9'h1AA, 9'h060, 9'h020, 9'h15C, 9'h12C, 9'h1C0};
        load0();
        start(2);
        wait_done0(3);
        checks++; if (g_cfg[0].ram[32] !== 9'h1AA) begin errors++; $display("FAIL st_ram: got %h, required 1aa", g_cfg[0].ram[32]); end
        checks++; if (g_cfg[0].n_wd !== 3) begin errors++; $display("FAIL st_wd_cycles: got %0d, required 3", g_cfg[0].n_wd); end
        checks++; if (g_cfg[0].last_done_st !== 5'd16) begin errors++; $display("FAIL st_done_state: got %0d, required 16", g_cfg[0].last_done_st); end
        wait_done0(4);
        checks++; if (g_cfg[0].R[5] !== 9'h1AA) begin errors++; $display("FAIL ld_r5: got %h, required 1aa", g_cfg[0].R[5]); end
    endtask

    task automatic test_mvnz();
        pq = {9'h048, 9'h003, 9'h070, 9'h005, 9'h1B1, 9'h040, 9'h1FE, 9'h081, 9'h1B1, 9'h1C0};
        load0();
        start(0);
        wait_done0(3);
        checks++; if (g_cfg[0].R[6] !== 9'h005) begin errors++; $display("FAIL mvnz_g0_r6: got %h, required 005", g_cfg[0].R[6]); end
        checks++; if (g_cfg[0].last_done_st !== 5'd4) begin errors++; $display("FAIL mvnz_g0_done: got %0d, required 4", g_cfg[0].last_done_st); end
        wait_done0(6);
        checks++; if (g_cfg[0].R[0] !== 9'h001) begin errors++; $display("FAIL mvnz_add_r0: got %h, required 001", g_cfg[0].R[0]); end
        checks++; if (g_cfg[0].R[6] !== 9'h003) begin errors++; $display("FAIL mvnz_g1_r6: got %h, required 003", g_cfg[0].R[6]); end
    endtask

    task automatic test_freeze_halt();
        pq = {9'h040, 9'h007, 9'h048, 9'h003, 9'h081, 9'h1C0};
        load0();
        start(0);
        for (int i = 0; i < 200 && g_cfg[0].state !== 5'd9; i++) @(negedge clk);
        checks++; if (g_cfg[0].state !== 5'd9) begin errors++; $display("FAIL reach_a2: got %0d, required 9", g_cfg[0].state); end
        run = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (g_cfg[0].state !== 5'd9) begin errors++; $display("FAIL freeze_state: got %0d, required 9", g_cfg[0].state); end
            checks++; if (g_cfg[0].strobes !== '0) begin errors++; $display("FAIL freeze_strobes: got %h, required 0", g_cfg[0].strobes); end
        end
        run = 1'b1;
        wait_done0(3);
        checks++; if (g_cfg[0].R[0] !== 9'h00A) begin errors++; $display("FAIL freeze_result: got %h, required 00a", g_cfg[0].R[0]); end
        checks++; if (g_cfg[0].n_as !== 0) begin errors++; $display("FAIL freeze_add_sub: got %0d, required 0", g_cfg[0].n_as); end
        for (int i = 0; i < 200 && g_cfg[0].halted !== 1'b1; i++) @(negedge clk);
        checks++; if (g_cfg[0].halted !== 1'b1 || g_cfg[0].state !== 5'd17) begin errors++;
            $display("FAIL halt_reached: got halted=%b state=%0d, required 1/17", g_cfg[0].halted, g_cfg[0].state); end
        repeat (10) @(negedge clk);
        checks++; if (g_cfg[0].halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b, required 1", g_cfg[0].halted); end
        checks++; if (g_cfg[0].strobes !== '0) begin errors++; $display("FAIL halt_strobes: got %h, required 0", g_cfg[0].strobes); end
        checks++; if (g_cfg[0].n_done !== 3) begin errors++; $display("FAIL halt_done_count: got %0d, required 3", g_cfg[0].n_done); end
        rst = 1'b0;
        #1;
        checks++; if (g_cfg[0].halted !== 1'b0 || g_cfg[0].state !== 5'd0) begin errors++;
            $display("FAIL halt_reset: got halted=%b state=%0d, required 0/0", g_cfg[0].halted, g_cfg[0].state); end
    endtask

    task automatic test_reset_mid_write();
        pq = {9'h058, 9'h1AA, 9'h060, 9'h020, 9'h15C, 9'h1C0};
        load0();
        start(5);
        for (int i = 0; i < 300 && g_cfg[0].w_d !== 1'b1; i++) @(negedge clk);
        checks++; if (g_cfg[0].w_d !== 1'b1) begin errors++; $display("FAIL reach_st_w: got w_d=%b, required 1", g_cfg[0].w_d); end
        #2 rst = 1'b0;
        #1;
        checks++; if (g_cfg[0].w_d !== 1'b0 || g_cfg[0].state !== 5'd0) begin errors++;
            $display("FAIL rst_mid_write: got w_d=%b state=%0d, required 0/0", g_cfg[0].w_d, g_cfg[0].state); end
        repeat (3) @(negedge clk);
        checks++; if (g_cfg[0].ram[32] !== 9'h000) begin errors++; $display("FAIL rst_no_write: got %h, required 000", g_cfg[0].ram[32]); end
    endtask

    task automatic test_rw4();
        start(0);
        for (int i = 0; i < 500 && g_cfg[1].n_done < 2; i++) @(negedge clk);
        checks++; if (g_cfg[1].R[15] !== 11'h040 || g_cfg[1].R[9] !== 11'h040) begin errors++;
            $display("FAIL rw4_mv_pc: got pc=%h r9=%h, required 040/040", g_cfg[1].R[15], g_cfg[1].R[9]); end
        for (int i = 0; i < 500 && g_cfg[1].n_done < 3; i++) @(negedge clk);
        checks++; if (g_cfg[1].R[2] !== 11'h055) begin errors++; $display("FAIL rw4_fetch_new_pc: got r2=%h, required 055", g_cfg[1].R[2]); end
        checks++; if (g_cfg[1].R[15] !== 11'h042) begin errors++; $display("FAIL rw4_pc_after: got %h, required 042", g_cfg[1].R[15]); end
        for (int i = 0; i < 500 && g_cfg[1].halted !== 1'b1; i++) @(negedge clk);
        checks++; if (g_cfg[1].halted !== 1'b1) begin errors++; $display("FAIL rw4_halt: got %b, required 1", g_cfg[1].halted); end
    endtask

    task automatic test_bus_rules();
        checks++; if (g_cfg[0].bus_viol !== 0) begin errors++; $display("FAIL bus_rule_rw3: got %0d cycles, required 0", g_cfg[0].bus_viol); end
        checks++; if (g_cfg[1].bus_viol !== 0) begin errors++; $display("FAIL bus_rule_rw4: got %0d cycles, required 0", g_cfg[1].bus_viol); end
        checks++; if (g_cfg[0].irin_viol !== 0) begin errors++; $display("FAIL ir_in_rw3: got %0d stray cycles, required 0", g_cfg[0].irin_viol); end
        checks++; if (g_cfg[1].irin_viol !== 0) begin errors++; $display("FAIL ir_in_rw4: got %0d stray cycles, required 0", g_cfg[1].irin_viol); end
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; load = 1'b0; mem_delay = 0;
        for (int i = 0; i < 2048; i++) g_cfg[1].prog[i] = '0;
        g_cfg[1].prog[0]  = 11'h190;   // MVI R9,#040
        g_cfg[1].prog[1]  = 11'h040;
        g_cfg[1].prog[2]  = 11'h0F9;   // MV R15,R9
        g_cfg[1].prog[64] = 11'h120;   // MVI R2,#055
        g_cfg[1].prog[65] = 11'h055;
        g_cfg[1].prog[66] = 11'h700;   // HALT
        test_reset();
        test_mvi();
        test_alu();
        test_st_ld();
        test_mvnz();
        test_freeze_halt();
        test_reset_mid_write();
        test_rw4();
        test_bus_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
